// File: rtl/piso_shift_register.sv
// Parallel-in/serial-out shift register: accepts a WIDTH-bit word over valid/ready
// and shifts it out one bit per clock with a per-bit valid and a last-bit strobe.
module piso_shift_register #(
  parameter int WIDTH      = 8,
  parameter bit MSB_FIRST  = 1'b0,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shreg, shreg_nxt;
  logic [CNT_W-1:0] bit_cnt, bit_cnt_nxt;

  logic last_bit;
  logic accept;

  // Every output is a decode of the registers, so nothing here depends on inputs.
  assign last_bit   = (state == SHIFT) && (bit_cnt == LAST_BIT);
  assign load_ready = (state == IDLE) || last_bit;
  assign ser_valid  = (state == SHIFT);
  assign busy       = (state == SHIFT);
  assign done       = last_bit;
  assign ser_out    = (state == SHIFT) ? (MSB_FIRST ? shreg[WIDTH-1] : shreg[0])
                                       : IDLE_LEVEL;

  assign accept = load_valid && load_ready;

  // NOTE: every variable gets its hold value first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_nxt   = state;
    shreg_nxt   = shreg;
    bit_cnt_nxt = bit_cnt;
    unique case (state)
      IDLE: begin
        if (accept) begin
          shreg_nxt   = load_data;
          bit_cnt_nxt = '0;
          state_nxt   = SHIFT;
        end
      end
      SHIFT: begin
        if (bit_cnt == LAST_BIT) begin
          // Reloading on the last bit keeps back-to-back words gap-free.
          if (accept) begin
            shreg_nxt   = load_data;
            bit_cnt_nxt = '0;
          end else begin
            bit_cnt_nxt = '0;
            state_nxt   = IDLE;
          end
        end else begin
          bit_cnt_nxt = bit_cnt + CNT_W'(1);
          if (MSB_FIRST) shreg_nxt = {shreg[WIDTH-2:0], 1'b0};
          else           shreg_nxt = {1'b0, shreg[WIDTH-1:1]};
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
    end else begin
      state   <= state_nxt;
      bit_cnt <= bit_cnt_nxt;
      shreg   <= shreg_nxt;
    end
  end

endmodule

// File: tb/tb_piso_shift_register.sv
// Self-checking bench for piso_shift_register: an LSB-first/idle-0 instance and an
// MSB-first/idle-1 instance share stimulus from a per-cycle vector table.
module tb_piso_shift_register;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             load_valid;
  logic [WIDTH-1:0] load_data;

  logic ready_l, out_l, valid_l, busy_l, done_l;
  logic ready_m, out_m, valid_m, busy_m, done_m;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  piso_shift_register #(.WIDTH(WIDTH), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) u_lsb (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_ready (ready_l),
    .load_data  (load_data),
    .ser_out    (out_l),
    .ser_valid  (valid_l),
    .busy       (busy_l),
    .done       (done_l)
  );

  piso_shift_register #(.WIDTH(WIDTH), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b1)) u_msb (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_ready (ready_m),
    .load_data  (load_data),
    .ser_out    (out_m),
    .ser_valid  (valid_m),
    .busy       (busy_m),
    .done       (done_m)
  );

  // One record per cycle: outputs expected in this cycle, then inputs for the next edge.
  typedef struct {
    logic       rst;
    logic       lv;
    logic [7:0] data;
    logic       sv;
    logic       dn;
    logic       rdy;
    logic       out_l;
    logic       out_m;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic lv, input logic [7:0] d,
                     input logic sv, input logic dn, input logic rdy,
                     input logic ol, input logic om);
    vec_t v;
    v.rst = r; v.lv = lv; v.data = d;
    v.sv = sv; v.dn = dn; v.rdy = rdy; v.out_l = ol; v.out_m = om;
    vecs.push_back(v);
  endtask

  // Idle cycle: no valid bit, ready, idle levels 0 (LSB instance) and 1 (MSB instance).
  task automatic add_idle(input logic r, input logic lv, input logic [7:0] d);
    add(r, lv, d, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
  endtask

  initial begin
    // 0xC1 = 1100_0001 sent LSB-first and MSB-first.
    logic c1_l[8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic c1_m[8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [7:0] word_l, word_m;
    int         nbits;
    bit         finished;

    // Post-reset idle, then a lone 0xC1.
    add_idle(1'b0, 1'b0, 8'h00);
    add_idle(1'b0, 1'b1, 8'hC1);
    for (int i = 0; i < 8; i++)
      add(1'b0, 1'b0, 8'h00, 1'b1, i == 7, i == 7, c1_l[i], c1_m[i]);

    // load_valid held high: 0xFF then 0x00 back to back.
    add_idle(1'b0, 1'b1, 8'hFF);
    for (int i = 0; i < 8; i++)
      add(1'b0, 1'b1, (i == 7) ? 8'h00 : 8'hFF, 1'b1, i == 7, i == 7, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++)
      add(1'b0, 1'b0, 8'h00, 1'b1, i == 7, i == 7, 1'b0, 1'b0);

    // 0x55 offered while bit 3 of 0xC1 is on the line must be ignored.
    add_idle(1'b0, 1'b1, 8'hC1);
    for (int i = 0; i < 8; i++)
      add(1'b0, i == 3, (i == 3) ? 8'h55 : 8'h00, 1'b1, i == 7, i == 7, c1_l[i], c1_m[i]);

    // Reset (with a competing load) during bit 3 of 0xC1 abandons the word.
    add_idle(1'b0, 1'b1, 8'hC1);
    for (int i = 0; i < 4; i++)
      add(i == 3, i == 3, (i == 3) ? 8'h55 : 8'h00, 1'b1, 1'b0, 1'b0, c1_l[i], c1_m[i]);
    add_idle(1'b0, 1'b0, 8'h00);
    add_idle(1'b0, 1'b0, 8'h00);
    add_idle(1'b0, 1'b0, 8'h00);

    // Reset held for two edges with load_valid high: nothing may be captured.
    rst        = 1'b1;
    load_valid = 1'b1;
    load_data  = 8'hAA;
    repeat (2) @(posedge clk);

    foreach (vecs[i]) begin
      @(negedge clk);
      check($sformatf("v%0d ser_valid_l", i), valid_l, vecs[i].sv);
      check($sformatf("v%0d busy_l", i),      busy_l,  vecs[i].sv);
      check($sformatf("v%0d done_l", i),      done_l,  vecs[i].dn);
      check($sformatf("v%0d ready_l", i),     ready_l, vecs[i].rdy);
      check($sformatf("v%0d ser_out_l", i),   out_l,   vecs[i].out_l);
      check($sformatf("v%0d ser_valid_m", i), valid_m, vecs[i].sv);
      check($sformatf("v%0d busy_m", i),      busy_m,  vecs[i].sv);
      check($sformatf("v%0d done_m", i),      done_m,  vecs[i].dn);
      check($sformatf("v%0d ready_m", i),     ready_m, vecs[i].rdy);
      check($sformatf("v%0d ser_out_m", i),   out_m,   vecs[i].out_m);
      rst        = vecs[i].rst;
      load_valid = vecs[i].lv;
      load_data  = vecs[i].data;
    end

    // Hand-written frame: reassemble 0x3C from both instances within a bounded window.
    @(negedge clk);
    load_valid = 1'b1;
    load_data  = 8'h3C;
    @(negedge clk);
    load_valid = 1'b0;
    load_data  = 8'h00;
    word_l   = '0;
    word_m   = '0;
    nbits    = 0;
    finished = 1'b0;
    for (int cyc = 0; cyc < 20 && !finished; cyc++) begin
      if (valid_l) begin
        if (nbits < 8) begin
          word_l[nbits]     = out_l;
          word_m[7 - nbits] = out_m;
        end
        nbits++;
      end
      if (done_l) finished = 1'b1;
      else @(negedge clk);
    end
    check("frame_done_seen", 32'(finished), 32'd1);
    check("frame_bit_count", nbits, 8);
    check("frame_word_lsb", 32'(word_l), 32'h3C);
    check("frame_word_msb", 32'(word_m), 32'h3C);
    @(negedge clk);
    check("frame_end_valid_l", valid_l, 1'b0);
    check("frame_end_ready_l", ready_l, 1'b1);
    check("frame_end_out_m", out_m, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
